// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the multiply/divide unit and the controller that
// drives it: MDUOp encodings, FSM state constants, default operation
// latencies and small op-classification helpers.
package mdu_pkg;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  // Plain constants rather than an enum so older tools reading the state
  // register see a simple 2-bit vector.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// mdu_core
// Combinational datapath of the multiply/divide unit. Produces the 64-bit
// {HI,LO} result for the latched operation and operands.
// Ports:
//   op       in  4   latched MDUOp
//   a        in  32  latched rs operand (dividend / multiplicand)
//   b        in  32  latched rt operand (divisor / multiplier)
//   result   out 64  {HI,LO} value for mult/multu/div/divu, 0 otherwise
//   div_zero out 1   op is div/divu and the divisor is zero
module mdu_core
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_s;
  logic [31:0] div_u;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  // The low 64 bits of a product of sign-extended operands equal the signed
  // 32x32 product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign div_zero = is_div_op(op) && (b == 32'd0);

  // Signed division on magnitudes: quotient sign is the XOR of operand signs
  // (truncation toward zero), remainder takes the dividend's sign. A zero
  // divisor is replaced by one so the dividers stay defined; that result is
  // never written back.
  assign mag_a  = a[31] ? (~a + 32'd1) : a;
  assign mag_b  = b[31] ? (~b + 32'd1) : b;
  assign div_s  = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign sq_mag = mag_a / div_s;
  assign sr_mag = mag_a % div_s;
  assign sq     = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign sr     = a[31] ? (~sr_mag + 32'd1) : sr_mag;

  assign div_u  = (b == 32'd0) ? 32'd1 : b;
  assign uq     = a / div_u;
  assign ur     = a % div_u;

  always_comb begin
    result = '0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = {sr, sq};
      MDU_DIVU:  result = {ur, uq};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit
// Multi-cycle multiply/divide unit for the E stage. Holds HI/LO, runs
// mult/multu/div/divu as timed operations and reports Busy for hazard stalls.
// Ports:
//   clk        in  1   core clock
//   reset      in  1   synchronous active-high reset
//   SrcA       in  32  rs operand (forwarded)
//   SrcB       in  32  rt operand (forwarded)
//   MDUOp      in  4   operation code (mdu_pkg encoding)
//   Start      in  1   launch pulse for mult/multu/div/divu
//   Busy       out 1   operation in flight
//   MDUResult  out 32  HI for mfhi, LO for mflo, 0 otherwise
//   HI         out 32  architectural HI
//   LO         out 32  architectural LO
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] MDUResult,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [3:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      core_result;
  logic             core_div_zero;
  logic             launch_mul;
  logic             launch_div;

  mdu_core u_core (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (core_result),
    .div_zero (core_div_zero)
  );

  assign launch_mul = Start && is_mul_op(MDUOp);
  assign launch_div = Start && is_div_op(MDUOp);

  // Operands are captured on the launch edge so the result ignores later
  // operand-bus changes. Start is only honoured in IDLE; the final busy
  // cycle loads HI/LO (unless dividing by zero) and drops back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      op_q  <= MDU_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch_mul) begin
            state <= S_MUL;
            count <= MULT_LOAD;
            op_q  <= MDUOp;
            a_q   <= SrcA;
            b_q   <= SrcB;
          end else if (launch_div) begin
            state <= S_DIV;
            count <= DIV_LOAD;
            op_q  <= MDUOp;
            a_q   <= SrcA;
            b_q   <= SrcB;
          end else if (MDUOp == MDU_MTHI) begin
            hi_q <= SrcA;
          end else if (MDUOp == MDU_MTLO) begin
            lo_q <= SrcA;
          end
        end
        S_MUL, S_DIV: begin
          if (count == CNT_ONE) begin
            state <= S_IDLE;
            count <= '0;
            if (!core_div_zero) begin
              hi_q <= core_result[63:32];
              lo_q <= core_result[31:0];
            end
          end else begin
            count <= count - CNT_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Reads see the registered values only; a same-cycle mthi/mtlo is not
  // forwarded.
  always_comb begin
    MDUResult = 32'd0;
    if (MDUOp == MDU_MFHI) begin
      MDUResult = hi_q;
    end else if (MDUOp == MDU_MFLO) begin
      MDUResult = lo_q;
    end
  end

  assign Busy = (state != S_IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit
// Scoreboard bench for mdu_unit: stimulus pushes expected completions and
// register reads into queues; a negedge monitor pops and compares them.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] MDUResult;
  logic [31:0] HI;
  logic [31:0] LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } op_exp_t;

  op_exp_t     op_q[$];
  logic [31:0] rd_q[$];
  op_exp_t     mon_e;
  logic [31:0] mon_rd;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  logic        busy_prev = 1'b0;
  int          busy_cnt = 0;

  mdu_unit dut (
    .clk       (clk),
    .reset     (reset),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .MDUOp     (MDUOp),
    .Start     (Start),
    .Busy      (Busy),
    .MDUResult (MDUResult),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural result of an operation from plain
  // arithmetic on 64-bit integers.
  task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int cyc);
    longint          sa;
    longint          sb;
    longint          p;
    longint          q;
    longint          r;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    hi = model_hi;
    lo = model_lo;
    cyc = 10;
    case (op)
      MDU_MULT: begin
        p = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
        cyc = 5;
      end
      MDU_MULTU: begin
        up = ua * ub;
        hi = up[63:32];
        lo = up[31:0];
        cyc = 5;
      end
      MDU_DIV: begin
        if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      MDU_DIVU: begin
        if (b != 32'd0) begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: cyc = 0;
    endcase
  endtask

  task automatic waitIdle();
    int k = 0;
    while (Busy && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("busy_timeout", {63'd0, Busy}, 64'd0);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_exp_t e;
    modelOp(op, a, b, e.hi, e.lo, e.cycles);
    op_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    @(posedge clk); #1;
    MDUOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = MDU_NONE;
    SrcA = $urandom; SrcB = $urandom;
    waitIdle();
  endtask

  task automatic writeReg(input logic [3:0] op, input logic [31:0] v);
    @(posedge clk); #1;
    MDUOp = op; SrcA = v;
    if (op == MDU_MTHI) model_hi = v; else model_lo = v;
    @(posedge clk); #1;
    MDUOp = MDU_NONE;
  endtask

  task automatic readReg(input logic [3:0] op);
    @(posedge clk); #1;
    MDUOp = op;
    rd_q.push_back(op == MDU_MFHI ? model_hi : model_lo);
    @(posedge clk); #1;
    MDUOp = MDU_NONE;
  endtask

  // Monitor: pops an expected completion when Busy falls and an expected
  // read value whenever mfhi/mflo is presented.
  always @(negedge clk) begin
    if (reset) begin
      busy_prev = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (Busy) busy_cnt++;
      if (busy_prev && !Busy) begin
        if (op_q.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = op_q.pop_front();
          checkOutput("done_hi", HI, mon_e.hi);
          checkOutput("done_lo", LO, mon_e.lo);
          checkOutput("busy_cycles", busy_cnt, mon_e.cycles);
        end
        busy_cnt = 0;
      end
      busy_prev = Busy;
      if (MDUOp == MDU_MFHI || MDUOp == MDU_MFLO) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_read", 64'd1, 64'd0);
        end else begin
          mon_rd = rd_q.pop_front();
          checkOutput("mdu_result", MDUResult, mon_rd);
        end
      end
    end
  end

  initial begin
    op_exp_t e;
    int sel;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1; SrcA = '0; SrcB = '0; MDUOp = MDU_NONE; Start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_busy", {63'd0, Busy}, 64'd0);
    checkOutput("reset_hi", HI, 64'd0);
    checkOutput("reset_lo", LO, 64'd0);
    checkOutput("reset_result", MDUResult, 64'd0);

    applyStimulus(MDU_MULT, 32'hFFFFFFFF, 32'h00000002);
    checkOutput("mult_hi", HI, 64'hFFFFFFFF);
    checkOutput("mult_lo", LO, 64'hFFFFFFFE);
    applyStimulus(MDU_MULTU, 32'hFFFFFFFF, 32'h00000002);
    checkOutput("multu_hi", HI, 64'h00000001);
    checkOutput("multu_lo", LO, 64'hFFFFFFFE);
    applyStimulus(MDU_DIV, 32'hFFFFFFF9, 32'h00000002);
    checkOutput("div_lo", LO, 64'hFFFFFFFD);
    checkOutput("div_hi", HI, 64'hFFFFFFFF);
    applyStimulus(MDU_DIVU, 32'd7, 32'd2);
    checkOutput("divu_lo", LO, 64'd3);
    checkOutput("divu_hi", HI, 64'd1);

    writeReg(MDU_MTHI, 32'h11);
    writeReg(MDU_MTLO, 32'h22);
    applyStimulus(MDU_DIVU, 32'd5, 32'd0);
    checkOutput("divzero_hi", HI, 64'h11);
    checkOutput("divzero_lo", LO, 64'h22);
    readReg(MDU_MFHI);
    readReg(MDU_MFLO);

    // mthi immediately followed by mfhi
    @(posedge clk); #1;
    MDUOp = MDU_MTHI; SrcA = 32'hAB; model_hi = 32'hAB;
    @(posedge clk); #1;
    MDUOp = MDU_MFHI; rd_q.push_back(model_hi);
    @(posedge clk); #1;
    MDUOp = MDU_NONE;

    // Start while busy must be ignored
    modelOp(MDU_MULT, 32'd3, 32'd4, e.hi, e.lo, e.cycles);
    op_q.push_back(e);
    model_hi = e.hi; model_lo = e.lo;
    @(posedge clk); #1;
    MDUOp = MDU_MULT; SrcA = 32'd3; SrcB = 32'd4; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = MDU_NONE;
    @(posedge clk); #1;
    MDUOp = MDU_DIVU; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = MDU_NONE;
    waitIdle();
    checkOutput("ignored_start_lo", LO, 64'd12);

    // reset during cycle 3 of a divide
    writeReg(MDU_MTHI, 32'h5555);
    writeReg(MDU_MTLO, 32'h6666);
    @(posedge clk); #1;
    MDUOp = MDU_DIVU; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = MDU_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_hi = 32'd0; model_lo = 32'd0;
    checkOutput("abort_busy", {63'd0, Busy}, 64'd0);
    checkOutput("abort_hi", HI, 64'd0);
    checkOutput("abort_lo", LO, 64'd0);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abort_late_hi", HI, 64'd0);
    checkOutput("abort_late_lo", LO, 64'd0);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 5);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      case (sel)
        0: applyStimulus(MDU_MULT, ra, rb);
        1: applyStimulus(MDU_MULTU, ra, rb);
        2: applyStimulus(MDU_DIV, ra, rb);
        3: applyStimulus(MDU_DIVU, ra, rb);
        4: writeReg(MDU_MTHI, ra);
        default: writeReg(MDU_MTLO, ra);
      endcase
      readReg(MDU_MFHI);
      readReg(MDU_MFLO);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("op_queue_drained", op_q.size(), 64'd0);
    checkOutput("read_queue_drained", rd_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
